state_dump_serializer: RTL and testbench
========================================

// Module: state_dump_serializer
// PURPOSE
// - Parametrised successor of the state dumping unit: streams a debug snapshot of the core to the UART TX byte interface.
// - Frame order: header, register file, flat pipeline snapshot of generic width, then memory section (step diff or address range).
// - Sits between the debug controller (trigger/done), the frozen core taps, the data-memory debug read port and uart_tx.
// PARAMETERS
// - N_REGS     32    register words read via rf_dbg port (1..32)
// - SNAP_W     608   width of snapshot vector; sent as ceil(SNAP_W/32) words, zero-padded MSBs
// - MAX_WORDS  1024  cap on memory payload words in range mode
// - ALERT      8'hDA first byte of every frame
// PORTS
// - clk_i            in   1       clock
// - rst_ni           in   1       synchronous active-low reset
// - dump_trigger_i   in   1       level request; accepted in IDLE
// - dump_mem_mode_i  in   1       0 = step (diff), 1 = continuous (range); sampled at accept
// - dump_done_o      out  1       frame complete; high in DONE
// - tx_data_o        out  8       byte to transmit
// - tx_start_o       out  1       byte valid/request, held until tx_done_i
// - tx_done_i        in   1       one-cycle pulse: byte transmitted
// - rf_dbg_addr_o    out  5       register index; rf_dbg_data_i valid same cycle (comb read)
// - rf_dbg_data_i    in   32      register data
// - snap_i           in   SNAP_W  flat pipeline/hazard state; latched at accept
// - dmem_addr_o      out  32      memory read address; dmem_data_i valid same cycle
// - dmem_data_i      in   32      memory read data
// - dmem_we_snoop_i  in   1       core store strobe (step diff)
// - dmem_addr_snoop_i in  32      core store address
// - dmem_wdata_snoop_i in 32      core store data
// - min_addr_i       in   32      range start (word aligned, bits[1:0] forced 0)
// - max_addr_i       in   32      range end, inclusive (bits[1:0] forced 0)
// BEHAVIOUR
// - Reset: state IDLE; tx_start_o=0, tx_data_o=0, dump_done_o=0, rf_dbg_addr_o=0, dmem_addr_o=0; all counters/latches 0.
// - Reset mid-frame aborts immediately to IDLE; no partial byte completion; next frame restarts at ALERT.
// - States: IDLE -> HDR -> REGS -> SNAP -> MCFG -> MDATA -> [CSUM] -> DONE -> IDLE.
// - Accept: IDLE & dump_trigger_i -> latch mode, snap_i, snoop we/addr/wdata, min/max; enter HDR next cycle.
// - HDR: byte ALERT, then mode byte 8'h00/8'h01.
// - REGS: for r=0..N_REGS-1: drive rf_dbg_addr_o=r, capture word one cycle, send 4 bytes LSB first.
// - SNAP: words k=0..ceil(SNAP_W/32)-1 = snap latch bits [32k+31:32k], 4 bytes each, LSB first.
// - MCFG step: word {31'b0,we}, then snooped addr, then snooped data (3 words, 12 bytes), MDATA skipped.
// - MCFG range: min word, then end word; MDATA reads min..end step 4 via dmem_addr_o, 4 bytes each.
// - Range rules: max<min -> zero payload words, end word = max as given; span > MAX_WORDS -> end clamped to min+4*(MAX_WORDS-1), clamped end is the value sent; address arithmetic 32-bit, no wrap past 0xFFFF_FFFC.
// - Byte handshake: tx_start_o rises with tx_data_o stable; both held until tx_done_i=1; tx_start_o low >=1 cycle between bytes.
// - tx_done_i while tx_start_o=0 is ignored.
// - Word fetch: 1 cycle per word (address drive + capture) before its first byte; no other added latency.
// - DONE: dump_done_o=1; held while dump_trigger_i=1; trigger low -> IDLE next cycle, dump_done_o=0.
// - Trigger changes or mode/min/max changes during frame are ignored (latched at accept).
// - Frame length: 2 + 4*N_REGS + 4*ceil(SNAP_W/32) + (step ? 12 : 8 + 4*words) [+1 checksum].
// CONFIGURATION
// - DUMP_CHECKSUM_EN defined: CSUM state appends one byte = 8-bit mod-256 sum of every byte after ALERT (mode through last payload byte).
// - DUMP_CHECKSUM_EN undefined: no accumulator logic, MDATA/MCFG goes straight to DONE; frame one byte shorter.
// TESTING
// - Step, N_REGS=32, rf data=index, we=1, addr=0x8888, data=0x12345678 -> DA,00, x1 bytes 01,00,00,00, mem 01..,88..,78.., done=1.
// - Range min=0x1000 max=0x1004, mem[1000]=AAAABBBB, mem[1004]=CCCCDDDD -> cfg 00,10,00,00,04,10,00,00, payload BB,BB,AA,AA,DD,DD,CC,CC.
// - Range min=0x2000 max=0x1000 -> cfg bytes sent, zero payload, total bytes = 2+128+76+8, done.
// - Range span 2000 words, MAX_WORDS=4 -> 4 payload words, end field = min+12.
// - Trigger held after DONE -> done stays 1, no second frame; trigger low then high -> new frame starts with DA.
// - rst_ni low during REGS byte 50 -> outputs reset next cycle; re-trigger yields full frame from DA; with DUMP_CHECKSUM_EN last byte equals sum.

Source files
------------

// File: rtl/state_dump_serializer.sv
// -----------------------------------------------------------------------------
// state_dump_serializer
//
// Streams a debug snapshot of the frozen core to a UART TX byte interface.
// Frame layout: ALERT byte and mode byte, then the register file, then the
// flat snapshot vector, then the memory section. The memory section is either
// a step diff (store strobe, address and data) or an address range read back
// through the data-memory debug port.
//
// Optional feature: define DUMP_CHECKSUM_EN to append one mod-256 checksum
// byte. The checksum covers every byte after ALERT. Without the macro the
// frame ends after the memory section and no accumulator is built.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   dump_trigger_i       level request, accepted in IDLE
//   dump_mem_mode_i      0 = step diff, 1 = address range (sampled at accept)
//   dump_done_o          high while the finished frame is being acknowledged
//   tx_data_o/tx_start_o byte and request toward uart_tx, held until tx_done_i
//   tx_done_i            one-cycle pulse, byte transmitted
//   rf_dbg_addr_o/_data_i register file debug read (combinational read)
//   snap_i               flat pipeline/hazard state, latched at accept
//   dmem_addr_o/_data_i  data memory debug read (combinational read)
//   dmem_*_snoop_i       core store strobe/address/data, latched at accept
//   min_addr_i/max_addr_i inclusive word range for range mode
// -----------------------------------------------------------------------------
module state_dump_serializer #(
    parameter int         N_REGS    = 32,
    parameter int         SNAP_W    = 608,
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] ALERT     = 8'hDA
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dump_trigger_i,
    input  logic              dump_mem_mode_i,
    output logic              dump_done_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_done_i,
    output logic [4:0]        rf_dbg_addr_o,
    input  logic [31:0]       rf_dbg_data_i,
    input  logic [SNAP_W-1:0] snap_i,
    output logic [31:0]       dmem_addr_o,
    input  logic [31:0]       dmem_data_i,
    input  logic              dmem_we_snoop_i,
    input  logic [31:0]       dmem_addr_snoop_i,
    input  logic [31:0]       dmem_wdata_snoop_i,
    input  logic [31:0]       min_addr_i,
    input  logic [31:0]       max_addr_i
);

    localparam int SNAP_WORDS = (SNAP_W + 31) / 32;
    localparam int CNT_A      = (N_REGS > SNAP_WORDS) ? N_REGS : SNAP_WORDS;
    localparam int CNT_MAX    = (CNT_A > MAX_WORDS) ? CNT_A : MAX_WORDS;
    localparam int IDX_W      = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] REG_LAST  = IDX_W'(N_REGS - 1);
    localparam logic [IDX_W-1:0] SNAP_LAST = IDX_W'(SNAP_WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TWO   = IDX_W'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_REGS, S_SNAP, S_MCFG, S_MDATA, S_CSUM, S_DONE
    } state_t;

    // Per-word sequencing: FETCH captures the word and raises the first byte,
    // SEND waits for tx_done_i, GAP keeps tx_start low for one cycle and picks
    // the next byte or the next word.
    typedef enum logic [1:0] {PH_FETCH, PH_SEND, PH_GAP} phase_t;

`ifdef DUMP_CHECKSUM_EN
    localparam state_t S_AFTER    = S_CSUM;
    localparam logic   AFTER_DONE = 1'b0;
`else
    localparam state_t S_AFTER    = S_DONE;
    localparam logic   AFTER_DONE = 1'b1;
`endif

    state_t                    state_q;
    phase_t                    ph_q;
    logic [IDX_W-1:0]          idx_q;
    logic [1:0]                byte_q;
    logic [31:8]               word_q;
    logic [7:0]                tx_data_q;
    logic                      tx_start_q;
    logic                      done_q;
    logic [4:0]                rf_addr_q;
    logic [31:0]               dmem_addr_q;
    logic                      mode_q;
    logic                      we_q;
    logic [31:0]               saddr_q;
    logic [31:0]               swdata_q;
    logic [31:0]               min_q;
    logic [31:0]               end_q;
    logic [IDX_W-1:0]          words_q;
    logic [SNAP_WORDS*32-1:0]  snap_q;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]                sum_q;
`endif

    // Range decode from the live inputs; only consumed at the accept edge.
    logic [31:0]      min_m;
    logic [31:0]      max_m;
    logic [29:0]      span_m1;
    logic [31:0]      end_d;
    logic [IDX_W-1:0] words_d;

    always_comb begin
        min_m   = min_addr_i & 32'hFFFF_FFFC;
        max_m   = max_addr_i & 32'hFFFF_FFFC;
        span_m1 = 30'((max_m - min_m) >> 2);
        end_d   = max_m;
        words_d = '0;
        if (max_m < min_m) begin
            end_d   = max_m;
            words_d = '0;
        end else if (span_m1 >= 30'(MAX_WORDS)) begin
            // Clamped end never exceeds max, so it cannot wrap past the top.
            end_d   = min_m + 32'(4 * (MAX_WORDS - 1));
            words_d = IDX_W'(MAX_WORDS);
        end else begin
            words_d = IDX_W'(span_m1 + 30'd1);
        end
    end

    // Word to be captured in the FETCH cycle of the current section.
    logic [31:0]       word_src;
    logic [IDX_W+4:0]  snap_base;

    always_comb begin
        word_src  = '0;
        snap_base = {idx_q, 5'b0};
        case (state_q)
            S_HDR:   word_src = {23'b0, mode_q, ALERT};
            S_REGS:  word_src = rf_dbg_data_i;
            S_SNAP:  word_src = snap_q[snap_base +: 32];
            S_MCFG: begin
                if (mode_q) begin
                    word_src = (idx_q == '0) ? min_q : end_q;
                end else begin
                    case (idx_q)
                        '0:      word_src = {31'b0, we_q};
                        IDX_ONE: word_src = saddr_q;
                        default: word_src = swdata_q;
                    endcase
                end
            end
            S_MDATA: word_src = dmem_data_i;
`ifdef DUMP_CHECKSUM_EN
            S_CSUM:  word_src = {24'b0, sum_q};
`endif
            default: word_src = '0;
        endcase
    end

    // Header carries two bytes, checksum one, every other word four.
    logic [1:0] last_b;
    logic [7:0] next_byte;

    always_comb begin
        if (state_q == S_HDR) begin
            last_b = 2'd1;
        end else if (state_q == S_CSUM) begin
            last_b = 2'd0;
        end else begin
            last_b = 2'd3;
        end
        case (byte_q)
            2'd0:    next_byte = word_q[15:8];
            2'd1:    next_byte = word_q[23:16];
            default: next_byte = word_q[31:24];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ph_q        <= PH_FETCH;
            idx_q       <= '0;
            byte_q      <= '0;
            word_q      <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            done_q      <= 1'b0;
            rf_addr_q   <= '0;
            dmem_addr_q <= '0;
            mode_q      <= 1'b0;
            we_q        <= 1'b0;
            saddr_q     <= '0;
            swdata_q    <= '0;
            min_q       <= '0;
            end_q       <= '0;
            words_q     <= '0;
            snap_q      <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (dump_trigger_i) begin
                        mode_q   <= dump_mem_mode_i;
                        snap_q   <= (SNAP_WORDS * 32)'(snap_i);
                        we_q     <= dmem_we_snoop_i;
                        saddr_q  <= dmem_addr_snoop_i;
                        swdata_q <= dmem_wdata_snoop_i;
                        min_q    <= min_m;
                        end_q    <= end_d;
                        words_q  <= words_d;
                        idx_q    <= '0;
                        byte_q   <= '0;
                        ph_q     <= PH_FETCH;
                        state_q  <= S_HDR;
`ifdef DUMP_CHECKSUM_EN
                        sum_q    <= '0;
`endif
                    end
                end
                S_DONE: begin
                    if (!dump_trigger_i) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    case (ph_q)
                        PH_FETCH: begin
                            word_q     <= word_src[31:8];
                            tx_data_q  <= word_src[7:0];
                            tx_start_q <= 1'b1;
                            byte_q     <= '0;
                            ph_q       <= PH_SEND;
                        end
                        PH_SEND: begin
                            if (tx_done_i) begin
                                tx_start_q <= 1'b0;
                                ph_q       <= PH_GAP;
`ifdef DUMP_CHECKSUM_EN
                                // ALERT is excluded from the sum.
                                if (!(state_q == S_HDR && byte_q == 2'd0)) begin
                                    sum_q <= sum_q + tx_data_q;
                                end
`endif
                            end
                        end
                        PH_GAP: begin
                            if (byte_q != last_b) begin
                                byte_q     <= byte_q + 2'd1;
                                tx_data_q  <= next_byte;
                                tx_start_q <= 1'b1;
                                ph_q       <= PH_SEND;
                            end else begin
                                ph_q  <= PH_FETCH;
                                idx_q <= idx_q + 1'b1;
                                case (state_q)
                                    S_HDR: begin
                                        idx_q     <= '0;
                                        rf_addr_q <= '0;
                                        state_q   <= S_REGS;
                                    end
                                    S_REGS: begin
                                        if (idx_q == REG_LAST) begin
                                            idx_q   <= '0;
                                            state_q <= S_SNAP;
                                        end else begin
                                            rf_addr_q <= rf_addr_q + 5'd1;
                                        end
                                    end
                                    S_SNAP: begin
                                        if (idx_q == SNAP_LAST) begin
                                            idx_q   <= '0;
                                            state_q <= S_MCFG;
                                        end
                                    end
                                    S_MCFG: begin
                                        if (mode_q ? (idx_q == IDX_ONE) : (idx_q == IDX_TWO)) begin
                                            idx_q <= '0;
                                            if (mode_q && words_q != '0) begin
                                                dmem_addr_q <= min_q;
                                                state_q     <= S_MDATA;
                                            end else begin
                                                done_q  <= AFTER_DONE;
                                                state_q <= S_AFTER;
                                            end
                                        end
                                    end
                                    S_MDATA: begin
                                        if (idx_q == words_q - 1'b1) begin
                                            idx_q   <= '0;
                                            done_q  <= AFTER_DONE;
                                            state_q <= S_AFTER;
                                        end else begin
                                            dmem_addr_q <= dmem_addr_q + 32'd4;
                                        end
                                    end
                                    S_CSUM: begin
                                        done_q  <= 1'b1;
                                        state_q <= S_DONE;
                                    end
                                    default: state_q <= S_IDLE;
                                endcase
                            end
                        end
                        default: ph_q <= PH_FETCH;
                    endcase
                end
            endcase
        end
    end

    assign dump_done_o   = done_q;
    assign tx_data_o     = tx_data_q;
    assign tx_start_o    = tx_start_q;
    assign rf_dbg_addr_o = rf_addr_q;
    assign dmem_addr_o   = dmem_addr_q;

endmodule

// File: tb/tb_state_dump_serializer.sv
// -----------------------------------------------------------------------------
// Bench for state_dump_serializer. A byte-level UART responder collects every
// transmitted byte with random handshake latency and stray done pulses; the
// expected frame is assembled from the frame rules as a byte queue.
// -----------------------------------------------------------------------------
module tb_state_dump_serializer;

    localparam int N_REGS     = 32;
    localparam int SNAP_W     = 608;
    localparam int MAX_WORDS  = 4;
    localparam int SNAP_WORDS = (SNAP_W + 31) / 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int MEM_OFS = 2 + 4 * N_REGS + 4 * SNAP_WORDS;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              dump_trigger_i;
    logic              dump_mem_mode_i;
    logic              dump_done_o;
    logic [7:0]        tx_data_o;
    logic              tx_start_o;
    logic              tx_done_i;
    logic [4:0]        rf_dbg_addr_o;
    logic [31:0]       rf_dbg_data_i;
    logic [SNAP_W-1:0] snap_i;
    logic [31:0]       dmem_addr_o;
    logic [31:0]       dmem_data_i;
    logic              dmem_we_snoop_i;
    logic [31:0]       dmem_addr_snoop_i;
    logic [31:0]       dmem_wdata_snoop_i;
    logic [31:0]       min_addr_i;
    logic [31:0]       max_addr_i;

    always #5 clk = ~clk;

    state_dump_serializer #(
        .N_REGS(N_REGS), .SNAP_W(SNAP_W), .MAX_WORDS(MAX_WORDS), .ALERT(8'hDA)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dump_trigger_i(dump_trigger_i), .dump_mem_mode_i(dump_mem_mode_i),
        .dump_done_o(dump_done_o),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
        .rf_dbg_addr_o(rf_dbg_addr_o), .rf_dbg_data_i(rf_dbg_data_i),
        .snap_i(snap_i),
        .dmem_addr_o(dmem_addr_o), .dmem_data_i(dmem_data_i),
        .dmem_we_snoop_i(dmem_we_snoop_i), .dmem_addr_snoop_i(dmem_addr_snoop_i),
        .dmem_wdata_snoop_i(dmem_wdata_snoop_i),
        .min_addr_i(min_addr_i), .max_addr_i(max_addr_i)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [N_REGS];
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hAAAA_BBBB;
        if (a == 32'h0000_1004) return 32'hCCCC_DDDD;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    always_comb rf_dbg_data_i = regs[rf_dbg_addr_o];
    always_comb dmem_data_i   = mem_word(dmem_addr_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- UART responder ----------------
    int          rsp_wait = 0;
    logic        rsp_just_done = 1'b0;
    logic        rsp_holding = 1'b0;
    logic [7:0]  rsp_held = 8'h00;

    initial begin
        tx_done_i = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_i = 1'b0;
            if (rsp_just_done) begin
                chk("start_gap", tx_start_o, 1'b0);
                rsp_just_done = 1'b0;
            end
            if (tx_start_o === 1'b1) begin
                if (!rsp_holding) begin
                    rsp_holding = 1'b1;
                    rsp_held    = tx_data_o;
                end else begin
                    chk("data_stable", tx_data_o, rsp_held);
                end
                if (rsp_wait == 0) begin
                    cap_q.push_back(tx_data_o);
                    tx_done_i     = 1'b1;
                    rsp_just_done = 1'b1;
                    rsp_holding   = 1'b0;
                    rsp_wait      = $urandom_range(0, 3);
                end else begin
                    rsp_wait--;
                end
            end else begin
                rsp_holding = 1'b0;
                if ($urandom_range(0, 3) == 0) tx_done_i = 1'b1;
            end
        end
    end

    // ---------------- reference frame ----------------
    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic build_expected(input logic mode, input logic we,
                                  input logic [31:0] sa, input logic [31:0] sd,
                                  input logic [31:0] mn, input logic [31:0] mx,
                                  input logic [SNAP_W-1:0] snap);
        logic [31:0] w, lo, hi, e;
        longint n;
        logic [7:0] s;
        exp_q.delete();
        exp_q.push_back(8'hDA);
        exp_q.push_back(mode ? 8'h01 : 8'h00);
        for (int r = 0; r < N_REGS; r++) push_word(regs[r]);
        for (int k = 0; k < SNAP_WORDS; k++) begin
            w = '0;
            for (int b = 0; b < 32; b++)
                if (32 * k + b < SNAP_W) w[b] = snap[32 * k + b];
            push_word(w);
        end
        if (!mode) begin
            push_word({31'b0, we});
            push_word(sa);
            push_word(sd);
        end else begin
            lo = mn & 32'hFFFF_FFFC;
            hi = mx & 32'hFFFF_FFFC;
            e  = hi;
            if (hi < lo) begin
                n = 0;
            end else begin
                n = (longint'(hi) - longint'(lo)) / 4 + 1;
                if (n > MAX_WORDS) begin
                    n = MAX_WORDS;
                    e = lo + 32'(4 * (MAX_WORDS - 1));
                end
            end
            push_word(lo);
            push_word(e);
            for (longint i = 0; i < n; i++) push_word(mem_word(lo + 32'(4 * i)));
        end
        if (EXTRA == 1) begin
            s = 8'h00;
            for (int i = 1; i < exp_q.size(); i++) s = s + exp_q[i];
            exp_q.push_back(s);
        end
    endtask

    function automatic logic [SNAP_W-1:0] rand_snap();
        logic [SNAP_W-1:0] v;
        for (int k = 0; k < SNAP_WORDS; k++) v[32 * k +: 32] = $urandom;
        return v;
    endfunction

    task automatic start_frame(input logic mode, input logic we,
                               input logic [31:0] sa, input logic [31:0] sd,
                               input logic [31:0] mn, input logic [31:0] mx,
                               input logic [SNAP_W-1:0] snap);
        @(negedge clk);
        dump_mem_mode_i    = mode;
        dmem_we_snoop_i    = we;
        dmem_addr_snoop_i  = sa;
        dmem_wdata_snoop_i = sd;
        min_addr_i         = mn;
        max_addr_i         = mx;
        snap_i             = snap;
        build_expected(mode, we, sa, sd, mn, mx, snap);
        cap_q.delete();
        dump_trigger_i = 1'b1;
        @(posedge clk);
        #1;
        // Everything sampled at accept; later changes must not matter.
        dump_mem_mode_i    = $urandom_range(0, 1);
        dmem_we_snoop_i    = $urandom_range(0, 1);
        dmem_addr_snoop_i  = $urandom;
        dmem_wdata_snoop_i = $urandom;
        min_addr_i         = $urandom;
        max_addr_i         = $urandom;
        snap_i             = rand_snap();
    endtask

    task automatic finish_frame(input string tag);
        int n;
        int sz;
        n = 0;
        while (dump_done_o !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done_rise"}, dump_done_o, 1'b1);
        chk({tag, " length"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp_q[i]);
        sz = cap_q.size();
        repeat (6) @(negedge clk);
        chk({tag, " done_held"}, dump_done_o, 1'b1);
        chk({tag, " no_refire"}, cap_q.size(), sz);
        dump_trigger_i = 1'b0;
        @(negedge clk);
        chk({tag, " done_clear"}, dump_done_o, 1'b0);
    endtask

    task automatic rand_regs();
        for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic [31:0] mn;
        rst_ni = 1'b0;
        dump_trigger_i = 1'b0;
        dump_mem_mode_i = 1'b0;
        dmem_we_snoop_i = 1'b0;
        dmem_addr_snoop_i = '0;
        dmem_wdata_snoop_i = '0;
        min_addr_i = '0;
        max_addr_i = '0;
        snap_i = '0;
        for (int r = 0; r < N_REGS; r++) regs[r] = 32'(r);
        repeat (3) @(negedge clk);
        chk("rst tx_start", tx_start_o, 1'b0);
        chk("rst tx_data", tx_data_o, 8'h00);
        chk("rst done", dump_done_o, 1'b0);
        chk("rst rf_addr", rf_dbg_addr_o, 5'd0);
        chk("rst dmem_addr", dmem_addr_o, 32'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle no_start", tx_start_o, 1'b0);

        // Step mode, register data = index.
        start_frame(1'b0, 1'b1, 32'h0000_8888, 32'h1234_5678, 32'h0, 32'h0, rand_snap());
        finish_frame("step");
        chk("step len_formula", cap_q.size(), MEM_OFS + 12 + EXTRA);
        chk("step alert", cap_q[0], 8'hDA);
        chk("step mode", cap_q[1], 8'h00);
        chk("step r1b0", cap_q[6], 8'h01);
        chk("step r1b1", cap_q[7], 8'h00);
        chk("step we", cap_q[MEM_OFS], 8'h01);
        chk("step addr", cap_q[MEM_OFS + 4], 8'h88);
        chk("step data", cap_q[MEM_OFS + 8], 8'h78);

        // Range 0x1000..0x1004.
        rand_regs();
        start_frame(1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_1000, 32'h0000_1004, rand_snap());
        finish_frame("range2");
        chk("range2 len_formula", cap_q.size(), MEM_OFS + 16 + EXTRA);
        chk("range2 min_b1", cap_q[MEM_OFS + 1], 8'h10);
        chk("range2 end_b0", cap_q[MEM_OFS + 4], 8'h04);
        chk("range2 w0_b0", cap_q[MEM_OFS + 8], 8'hBB);
        chk("range2 w0_b3", cap_q[MEM_OFS + 11], 8'hAA);
        chk("range2 w1_b0", cap_q[MEM_OFS + 12], 8'hDD);

        // Inverted range: configuration only.
        start_frame(1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_2000, 32'h0000_1000, rand_snap());
        finish_frame("inv");
        chk("inv len_formula", cap_q.size(), 214 + EXTRA);
        chk("inv end_b1", cap_q[MEM_OFS + 5], 8'h10);

        // Span of 2000 words clamps to MAX_WORDS.
        start_frame(1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_4000, 32'h0000_5F3C, rand_snap());
        finish_frame("clamp");
        chk("clamp len_formula", cap_q.size(), MEM_OFS + 8 + 16 + EXTRA);
        chk("clamp end_b0", cap_q[MEM_OFS + 4], 8'h0C);
        chk("clamp end_b1", cap_q[MEM_OFS + 5], 8'h40);

        // Top of address space with unaligned bounds.
        start_frame(1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF1, 32'hFFFF_FFFF, rand_snap());
        finish_frame("top");
        chk("top len_formula", cap_q.size(), MEM_OFS + 8 + 16 + EXTRA);

        // Random frames; the second one also wiggles the trigger mid-frame.
        for (int t = 0; t < 3; t++) begin
            rand_regs();
            mn = $urandom & 32'hFFFF_FFF0;
            start_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                        mn, mn + 32'($urandom_range(0, 24)), rand_snap());
            if (t == 1) begin
                repeat (20) @(negedge clk);
                dump_trigger_i = 1'b0;
                repeat (3) @(negedge clk);
                dump_trigger_i = 1'b1;
            end
            finish_frame($sformatf("rand%0d", t));
        end

        // Reset during the register section.
        rand_regs();
        start_frame(1'b0, 1'b1, $urandom, $urandom, 32'h0, 32'h0, rand_snap());
        n = 0;
        while (cap_q.size() < 50 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached_byte50", cap_q.size() >= 50, 1'b1);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        chk("abort tx_start", tx_start_o, 1'b0);
        chk("abort tx_data", tx_data_o, 8'h00);
        chk("abort done", dump_done_o, 1'b0);
        chk("abort rf_addr", rf_dbg_addr_o, 5'd0);
        dump_trigger_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort idle", tx_start_o, 1'b0);
        start_frame(1'b1, 1'b0, 32'h0, 32'h0, 32'h0000_1000, 32'h0000_1008, rand_snap());
        finish_frame("restart");
        chk("restart alert", cap_q[0], 8'hDA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
